// File: rtl/spu_writeback_queue.sv
// Write-back queue for the SPU execute stage.
// Completed results are dropped into a slotted shift queue at a depth equal to
// their remaining functional-unit latency. Slot 0 drives the register-file write
// port, so results retire one per cycle in order of completion. Pending results
// can be looked up by register address for operand forwarding.
module spu_writeback_queue #(
  parameter int DATA_W  = 128,
  parameter int REG_W   = 7,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [REG_W-1:0]  res_reg,
  input  logic [LAT_W-1:0]  res_latency,
  input  logic              flush,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_W-1:0]  fwd_reg,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [LAT_W:0]    occupancy
);

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } slot_t;

  // Slot i retires i cycles from now; invalid slots always hold zero fields.
  slot_t slots [MAX_LAT];

  // Accept unless flushing or the entry one slot deeper would shift onto the
  // target slot at this edge (same retire cycle = write-port collision).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    res_ready = 1'b0;
    if (!flush) begin
      if (res_latency == LAT_W'(MAX_LAT - 1)) begin
        res_ready = 1'b1;
      end else begin
        res_ready = !slots[res_latency + LAT_W'(1)].valid;
      end
    end
  end

  // Shift the queue one slot toward retirement, insert or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot array is a handful of flops, not a RAM, so clearing it in reset is cheap and keeps wb_*/fwd_* defined.
      for (int i = 0; i < MAX_LAT; i++) begin
        slots[i] <= '0;
      end
    end else if (flush) begin
      // Slot 0's write happens this cycle; slot 1 is dropped rather than promoted.
      for (int i = 0; i < MAX_LAT; i++) begin
        slots[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every slot read its neighbour's pre-edge value, giving a true shift.
      for (int i = 0; i < MAX_LAT - 1; i++) begin
        slots[i] <= slots[i+1];
      end
      slots[MAX_LAT-1] <= '0;
      if (res_valid && res_ready) begin
        slots[res_latency] <= '{valid: 1'b1, dst: res_reg, data: res_data};
      end
    end
  end

  // Slot 0 is the register-file write port.
  always_comb begin
    wb_en   = slots[0].valid;
    wb_reg  = slots[0].valid ? slots[0].dst  : '0;
    wb_data = slots[0].valid ? slots[0].data : '0;
  end

  // Forwarding lookup: the highest matching slot retires last and holds the final value.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (slots[i].valid && (slots[i].dst == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = slots[i].data;
      end
    end
  end

  // Count of valid slots, including the one being written this cycle.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      occupancy = occupancy + {{LAT_W{1'b0}}, slots[i].valid};
    end
  end

endmodule

// File: tb/tb_spu_writeback_queue.sv
// Self-checking bench for spu_writeback_queue. A model tracks pending results by
// absolute retire cycle; the compare process checks every output on each falling
// edge, and directed scenarios add hand-computed literal checks.
module tb_spu_writeback_queue;

  localparam int DATA_W  = 128;
  localparam int REG_W   = 7;
  localparam int MAX_LAT = 8;
  localparam int LAT_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              res_valid = 1'b0;
  logic              res_ready;
  logic [DATA_W-1:0] res_data = '0;
  logic [REG_W-1:0]  res_reg = '0;
  logic [LAT_W-1:0]  res_latency = '0;
  logic              flush = 1'b0;
  logic              wb_en;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  fwd_reg = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [LAT_W:0]    occupancy;

  spu_writeback_queue #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W),
    .MAX_LAT(MAX_LAT),
    .LAT_W  (LAT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_reg    (res_reg),
    .res_latency(res_latency),
    .flush      (flush),
    .wb_en      (wb_en),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .fwd_reg    (fwd_reg),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: pending results keyed by retire cycle -------------
  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
    int unsigned       t;
  } ent_t;

  ent_t        pend[$];
  int unsigned cyc = 0;

  // An accept now lands in cycle cyc+1+L; it is refused only if that write cycle is taken.
  function automatic logic m_ready(input logic [LAT_W-1:0] l, input logic fl);
    if (fl) return 1'b0;
    foreach (pend[i]) if (pend[i].t == cyc + 1 + int'(l)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (flush) begin
        for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].t > cyc) pend.delete(i);
      end else if (res_valid && m_ready(res_latency, flush)) begin
        pend.push_back('{r: res_reg, d: res_data, t: cyc + 1 + int'(res_latency)});
      end
      cyc++;
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].t < cyc) pend.delete(i);
    end
  end

  // ---------------- per-cycle comparison against the model -------------------
  logic              e_en, e_hit, e_rdy;
  logic [REG_W-1:0]  e_reg;
  logic [DATA_W-1:0] e_data, e_fd;
  int unsigned       e_occ, e_best;

  always @(negedge clk) begin
    e_en = 1'b0; e_reg = '0; e_data = '0; e_hit = 1'b0; e_fd = '0; e_occ = 0; e_best = 0;
    foreach (pend[i]) begin
      e_occ++;
      if (pend[i].t == cyc) begin
        e_en = 1'b1; e_reg = pend[i].r; e_data = pend[i].d;
      end
      if (pend[i].r == fwd_reg && (!e_hit || pend[i].t > e_best)) begin
        e_hit = 1'b1; e_fd = pend[i].d; e_best = pend[i].t;
      end
    end
    e_rdy = m_ready(res_latency, flush);
    check("wb_en", wb_en, e_en);
    check("wb_reg", wb_reg, e_reg);
    check("wb_data", wb_data, e_data);
    check("fwd_hit", fwd_hit, e_hit);
    check("fwd_data", fwd_data, e_fd);
    check("occupancy", occupancy, e_occ);
    check("res_ready", res_ready, e_rdy);
  end

  // ---------------- stimulus -------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REG_W-1:0] r,
                       input logic [DATA_W-1:0] d, input logic [LAT_W-1:0] l);
    res_valid = v; res_reg = r; res_data = d; res_latency = l;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_wb_en", wb_en, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single result, L=0
    drive(1'b1, 7'd5, {16{8'hA5}}, 3'd0);
    fwd_reg = 7'd5;
    step();
    idle();
    #1;
    check("single_wb_en", wb_en, 1);
    check("single_wb_reg", wb_reg, 5);
    check("single_wb_data", wb_data, {16{8'hA5}});
    step();
    check("single_after", wb_en, 0);

    // Mixed latency: reg 10 L=3 at cycle 0, reg 11 L=0 at cycle 2
    drive(1'b1, 7'd10, 128'h10, 3'd3);
    step();
    idle();
    step();
    drive(1'b1, 7'd11, 128'h11, 3'd0);
    #1;
    check("mixed_ready", res_ready, 1);
    step();
    idle();
    check("mixed_c3_reg", wb_reg, 11);
    step();
    check("mixed_c4_en", wb_en, 1);
    check("mixed_c4_reg", wb_reg, 10);
    step();
    check("mixed_c5_en", wb_en, 0);

    // Collision: L=2 at cycle 0 blocks L=1 at cycle 1
    drive(1'b1, 7'd30, 128'h30, 3'd2);
    step();
    drive(1'b1, 7'd31, 128'h31, 3'd1);
    #1;
    check("collide_ready_c1", res_ready, 0);
    step();
    check("collide_ready_c2", res_ready, 1);
    step();
    idle();
    check("collide_c3_reg", wb_reg, 30);
    check("collide_c3_occ", occupancy, 2);
    step();
    check("collide_c4_reg", wb_reg, 31);
    step();

    // Forwarding priority: reg 20 in slot 4 (data 2) and slot 1 (data 1)
    drive(1'b1, 7'd20, 128'd2, 3'd7);
    step();
    idle();
    step(); step();
    drive(1'b1, 7'd20, 128'd1, 3'd1);
    step();
    idle();
    fwd_reg = 7'd20;
    #1;
    check("fwd20_hit", fwd_hit, 1);
    check("fwd20_data", fwd_data, 2);
    fwd_reg = 7'd21;
    #1;
    check("fwd21_hit", fwd_hit, 0);
    check("fwd21_data", fwd_data, 0);
    repeat (6) step();

    // Flush: four equal-latency results back to back, slot 0 valid
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7'(40 + i), 128'(40 + i), 3'd3);
      step();
    end
    drive(1'b1, 7'd50, 128'h50, 3'd0);
    flush = 1'b1;
    #1;
    check("flush_ready", res_ready, 0);
    check("flush_wb_en", wb_en, 1);
    check("flush_wb_reg", wb_reg, 40);
    check("flush_occ_before", occupancy, 4);
    step();
    flush = 1'b0;
    idle();
    check("flush_wb_en_after", wb_en, 0);
    check("flush_occ_after", occupancy, 0);
    step();

    // Directed mix: varied latencies, duplicate destinations, held requests
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 7'(i % 5), 128'(i) * 128'h1_0000_0001, 3'((i * 3 + i / 4) % 8));
      fwd_reg = 7'((i + 2) % 5);
      step();
    end
    idle();
    repeat (2) step();

    // Reset mid-operation with three results pending
    drive(1'b1, 7'd60, 128'h60, 3'd6); step();
    drive(1'b1, 7'd61, 128'h61, 3'd6); step();
    drive(1'b1, 7'd62, 128'h62, 3'd6); step();
    idle();
    fwd_reg = 7'd61;
    check("pre_reset_occ", occupancy, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_wb_en", wb_en, 0);
    check("midrst_occ", occupancy, 0);
    check("midrst_fwd_hit", fwd_hit, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
